// File: rtl/serial_comp2_ctrl.sv
// Bit-serial two's-complement unit: pass, negate or absolute value, one bit per clock, LSB first.
// Complement is formed by copying bits up to and including the first 1, then inverting the rest.
module serial_comp2_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic             seen_one_q;
  logic             is_min_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;

  logic             bit_d;
  logic             out_bit_d;
  logic             neg_d;
  logic             is_min_d;
  logic             last_d;

  always_comb begin
    bit_d     = shreg_q[0];
    out_bit_d = (neg_q & seen_one_q) ? ~bit_d : bit_d;
    neg_d     = (op == 2'b01) | ((op == 2'b10) & a[WIDTH-1]);
    // The most negative value is its own complement; remember it for the overflow flag.
    is_min_d  = (a == {1'b1, {(WIDTH-1){1'b0}}});
    last_d    = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      seen_one_q <= 1'b0;
      is_min_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            shreg_q    <= a;
            neg_q      <= neg_d;
            is_min_q   <= is_min_d;
            seen_one_q <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          shreg_q    <= shreg_q >> 1;
          result_q   <= {out_bit_d, result_q[WIDTH-1:1]};
          seen_one_q <= seen_one_q | bit_d;
          cnt_q      <= cnt_q + CW'(1);
          if (last_d) begin
            done_q  <= 1'b1;
            ovf_q   <= neg_q & is_min_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule
